// File: rtl/word_context_product_pkg.sv
// word_context_product_pkg: shared Q7.8 fixed-point types and constants for the skip-gram dot-product cell.
package word_context_product_pkg;
  localparam int DIM   = 3;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int PW    = 2 * WIDTH - FRAC;
  localparam int ACC_W = PW + 2;
  typedef logic signed [WIDTH-1:0] fix_t;
  typedef logic [DIM-1:0][WIDTH-1:0] vec_t;
  localparam fix_t Q_MAX = 16'sh7FFF;
  localparam fix_t Q_MIN = 16'sh8000;
endpackage

// File: rtl/word_context_product_fixmul.sv
// word_context_product_fixmul: signed Q7.8 multiply, full product shifted right by FRAC (floor).
module word_context_product_fixmul
  import word_context_product_pkg::*;
(
  input  fix_t                 a_i,
  input  fix_t                 b_i,
  output logic signed [PW-1:0] p_o
);
  logic signed [2*WIDTH-1:0] prod;
  assign prod = a_i * b_i;
  assign p_o  = prod[2*WIDTH-1:FRAC];
endmodule

// File: rtl/word_context_product.sv
// word_context_product: registered ReLU(word . context) with its gradients w.r.t. both vectors.
module word_context_product
  import word_context_product_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  output logic [WIDTH-1:0]       y,
  output logic [DIM*WIDTH-1:0]   y_dword_vec,
  output logic [DIM*WIDTH-1:0]   y_dcontext_vec,
  input  logic [DIM*WIDTH-1:0]   word_embv,
  input  logic [DIM*WIDTH-1:0]   context_embv
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(Q_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(Q_MIN);
  logic signed [PW-1:0]    p [DIM];
  logic signed [ACC_W-1:0] sum;
  fix_t                    s_sat;
  logic                    active;
  logic [WIDTH-1:0]        y_d, y_q;
  logic [DIM*WIDTH-1:0]    dw_d, dw_q, dc_d, dc_q;
  for (genvar i = 0; i < DIM; i++) begin : g_mul
    word_context_product_fixmul u_mul (
      .a_i (fix_t'(word_embv[WIDTH*i +: WIDTH])),
      .b_i (fix_t'(context_embv[WIDTH*i +: WIDTH])),
      .p_o (p[i])
    );
  end
  // Accumulator is two bits wider than a product, so three terms never overflow.
  always_comb begin
    sum = '0;
    for (int k = 0; k < DIM; k++) sum = sum + {{(ACC_W-PW){p[k][PW-1]}}, p[k]};
    s_sat  = sum > ACC_MAX ? Q_MAX : sum < ACC_MIN ? Q_MIN : fix_t'(sum[WIDTH-1:0]);
    active = s_sat > 0;
    y_d    = active ? s_sat : '0;
    dw_d   = active ? context_embv : '0;
    dc_d   = active ? word_embv : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q  <= '0;
      dw_q <= '0;
      dc_q <= '0;
    end else begin
      y_q  <= y_d;
      dw_q <= dw_d;
      dc_q <= dc_d;
    end
  end
  assign y              = y_q;
  assign y_dword_vec    = dw_q;
  assign y_dcontext_vec = dc_q;
endmodule

// File: tb/tb_word_context_product.sv
// tb_word_context_product: directed + random scoreboard bench for the dot-product/ReLU cell.
module tb_word_context_product;
  typedef struct {
    logic [15:0] y;
    logic [47:0] dw;
    logic [47:0] dc;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] y;
  logic [47:0] y_dword_vec, y_dcontext_vec, word_embv, context_embv;
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  localparam logic [47:0] W_POS  = {16'h0300, 16'h0200, 16'h0100};
  localparam logic [47:0] C_ONE  = {16'h0100, 16'h0100, 16'h0100};
  localparam logic [47:0] C_NEG  = {16'hFF00, 16'hFF00, 16'hFF00};
  localparam logic [47:0] V_HALF = {16'h0000, 16'h0000, 16'h0080};
  localparam logic [47:0] V_LSB  = {16'h0000, 16'h0000, 16'h0001};
  localparam logic [47:0] V_BIG  = {16'h7F00, 16'h7F00, 16'h7F00};
  word_context_product dut (
    .clk            (clk),
    .reset          (reset),
    .y              (y),
    .y_dword_vec    (y_dword_vec),
    .y_dcontext_vec (y_dcontext_vec),
    .word_embv      (word_embv),
    .context_embv   (context_embv)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [47:0] w, input logic [47:0] c);
    exp_t   e;
    longint s = 0;
    for (int i = 0; i < 3; i++)
      s += (longint'($signed(w[16*i +: 16])) * longint'($signed(c[16*i +: 16]))) >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    e.y  = s > 0 ? s[15:0] : 16'h0;
    e.dw = s > 0 ? c : 48'h0;
    e.dc = s > 0 ? w : 48'h0;
    return e;
  endfunction
  function automatic exp_t mk(input logic [15:0] yv, input logic [47:0] dw, input logic [47:0] dc);
    exp_t e;
    e.y = yv; e.dw = dw; e.dc = dc;
    return e;
  endfunction
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic rst, input logic [47:0] w, input logic [47:0] c, input exp_t e);
    exp_t got;
    reset = rst; word_embv = w; context_embv = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fails++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, y);
    end else begin
      got = sb.pop_front();
      check({tag, ".y"}, {32'h0, y}, {32'h0, got.y});
      check({tag, ".dword"}, y_dword_vec, got.dw);
      check({tag, ".dcontext"}, y_dcontext_vec, got.dc);
    end
  endtask
  initial begin
    logic [47:0] rw, rc;
    reset = 1'b1; word_embv = W_POS; context_embv = C_ONE;
    step("reset0", 1'b1, W_POS, C_ONE, mk(16'h0, 48'h0, 48'h0));
    step("reset1", 1'b1, W_POS, C_ONE, mk(16'h0, 48'h0, 48'h0));
    step("pos", 1'b0, W_POS, C_ONE, mk(16'h0600, C_ONE, W_POS));
    step("neg", 1'b0, W_POS, C_NEG, mk(16'h0, 48'h0, 48'h0));
    step("half", 1'b0, V_HALF, V_HALF, mk(16'h0040, V_HALF, V_HALF));
    step("trunc", 1'b0, V_LSB, V_LSB, mk(16'h0, 48'h0, 48'h0));
    step("sat", 1'b0, V_BIG, V_BIG, mk(16'h7FFF, V_BIG, V_BIG));
    step("pre_rst", 1'b0, W_POS, C_ONE, mk(16'h0600, C_ONE, W_POS));
    step("mid_rst", 1'b1, W_POS, C_ONE, mk(16'h0, 48'h0, 48'h0));
    step("post_rst", 1'b0, W_POS, C_ONE, mk(16'h0600, C_ONE, W_POS));
    step("b2b_neg", 1'b0, W_POS, C_NEG, mk(16'h0, 48'h0, 48'h0));
    step("b2b_sat", 1'b0, V_BIG, V_BIG, mk(16'h7FFF, V_BIG, V_BIG));
    step("b2b_half", 1'b0, V_HALF, V_HALF, mk(16'h0040, V_HALF, V_HALF));
    step("b2b_pos", 1'b0, W_POS, C_ONE, mk(16'h0600, C_ONE, W_POS));
    step("negsat", 1'b0, V_BIG, {16'h8000, 16'h8000, 16'h8000}, mk(16'h0, 48'h0, 48'h0));
    for (int i = 0; i < 16; i++) begin
      rw = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      rc = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      if (i < 8) begin
        rw = rw & 48'h03FF_03FF_03FF;
        rc = rc & 48'h03FF_03FF_03FF;
      end
      step($sformatf("rnd%0d", i), 1'b0, rw, rc, model(rw, rc));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
